// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time against a word-addressed memory.
// Sub-word stores are read-modify-write since the memory has no byte enables.
module load_store_unit #(
  parameter int MEM_AW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        opcode,
  input  logic [31:0]       base,
  input  logic [15:0]       offset,
  input  logic [31:0]       rt_data,
  input  logic [4:0]        rt_addr,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_reg,
  output logic [31:0]       wb_data,
  output logic              st_done,
  output logic              fault,
  output logic [31:0]       fault_addr
);

  typedef enum logic [2:0] {
    IDLE,
    FAULT,
    LOAD,
    WRITE,
    RMW_READ,
    RMW_WRITE,
    DONE
  } state_t;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  state_t      state, state_d;
  logic [31:0] ea;
  logic        supp, is_w, is_h;
  logic        bad, accept;
  // op_q: [3]=store, [2]=unsigned, [1:0]=size (00 byte, 01 half, 11 word)
  logic [3:0]  op_q;
  logic [1:0]  lane_q;
  logic [15:0] rt_q;

  assign ea = base + {{16{offset[15]}}, offset};

  always_comb begin
    supp = 1'b0;
    is_w = 1'b0;
    is_h = 1'b0;
    unique case (opcode)
      OP_LW, OP_SW: begin
        supp = 1'b1;
        is_w = 1'b1;
      end
      OP_LH, OP_LHU, OP_SH: begin
        supp = 1'b1;
        is_h = 1'b1;
      end
      OP_LB, OP_LBU, OP_SB: supp = 1'b1;
      default: ;
    endcase
  end

  assign bad = (|(ea >> (MEM_AW + 2)))
             | (is_w & (|ea[1:0]))
             | (is_h & ea[0]);

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready & supp;

  function automatic logic [31:0] extract(
    input logic [31:0] w,
    input logic [1:0]  lane,
    input logic [2:0]  op
  );
    logic [7:0]  b;
    logic [15:0] h;
    unique case (lane)
      2'd0: b = w[31:24];
      2'd1: b = w[23:16];
      2'd2: b = w[15:8];
      default: b = w[7:0];
    endcase
    h = lane[1] ? w[15:0] : w[31:16];
    unique case (op[1:0])
      2'b00: extract = op[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01: extract = op[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: extract = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0] w,
    input logic [1:0]  lane,
    input logic        half,
    input logic [15:0] d
  );
    merge = w;
    if (half) begin
      if (lane[1]) merge[15:0] = d;
      else         merge[31:16] = d;
    end else begin
      unique case (lane)
        2'd0: merge[31:24] = d[7:0];
        2'd1: merge[23:16] = d[7:0];
        2'd2: merge[15:8]  = d[7:0];
        default: merge[7:0] = d[7:0];
      endcase
    end
  endfunction

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (bad)                     state_d = FAULT;
          else if (!opcode[3])         state_d = LOAD;
          else if (opcode[1:0] == 2'b11) state_d = WRITE;
          else                         state_d = RMW_READ;
        end
      end
      FAULT:     state_d = IDLE;
      LOAD:      state_d = DONE;
      WRITE:     state_d = DONE;
      RMW_READ:  state_d = RMW_WRITE;
      RMW_WRITE: state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      op_q       <= '0;
      lane_q     <= '0;
      rt_q       <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      wb_data    <= '0;
      wb_reg     <= '0;
      fault_addr <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        op_q     <= opcode[3:0];
        lane_q   <= ea[1:0];
        rt_q     <= rt_data[15:0];
        mem_addr <= ea[MEM_AW+1:2];
        wb_reg   <= rt_addr;
        if (opcode[3]) mem_wdata <= rt_data;
        if (bad) fault_addr <= ea;
      end
      if (state == LOAD)
        wb_data <= extract(mem_rdata, lane_q, op_q[2:0]);
      if (state == RMW_READ)
        mem_wdata <= merge(mem_rdata, lane_q, op_q[0], rt_q);
    end
  end

  // Pulses are masked during reset so an aborted operation never completes
  assign mem_we   = ~reset & ((state == WRITE) | (state == RMW_WRITE));
  assign fault    = ~reset & (state == FAULT);
  assign wb_valid = ~reset & (state == DONE) & ~op_q[3];
  assign st_done  = ~reset & (state == DONE) & op_q[3];

endmodule
